spectrum_bar_meter: RTL and testbench



---
 rtl/spectrum_bar_meter.sv | 211 +++++++++++++++++++++
 tb/tb_spectrum_bar_meter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_bar_meter.sv
// spectrum_bar_meter
//   Turns the packed FFT bin magnitudes into 4-bit bar levels for the
//   spectrum display. Bars attack instantly and decay on a timed tick. Peak
//   markers hold for a number of decay ticks before they start to fall.
//   Bins are processed serially, one per clock, so there is only one
//   magnitude datapath.
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_frame_valid  fft_done level; a rising edge announces a new frame
//   i_freqs        packed bins, bin k = [16k+15:16k], {re[7:0], im[7:0]} signed
//   o_bar          bar level per bin, bin k = [4k+3:4k]
//   o_peak         peak-hold level per bin, bin k = [4k+3:4k]
//   o_update       one-cycle pulse after a frame sweep completes
//   o_busy         high while sweeping (PROC or DECAY)
//   o_overrun      sticky, set when a frame edge had to be dropped
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a frame edge, a pending frame or a pending decay
// PROC  | sweeping the frame snapshot, one bin per cycle (attack/peak)
// DONE  | one cycle, raises o_update
// DECAY | sweeping all bins, one bin per cycle (bar/peak decay)
module spectrum_bar_meter #(
  parameter int NUM_BINS     = 16,
  parameter int LVL_SHIFT    = 4,
  parameter int DECAY_CYCLES = 1_000_000,
  parameter int HOLD_TICKS   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_frame_valid,
  input  logic [16*NUM_BINS-1:0]  i_freqs,
  output logic [4*NUM_BINS-1:0]   o_bar,
  output logic [4*NUM_BINS-1:0]   o_peak,
  output logic                    o_update,
  output logic                    o_busy,
  output logic                    o_overrun
);

  localparam int IDX_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int CNT_W  = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0]  DCNT_MAX  = CNT_W'(DECAY_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROC  = 2'd1,
    S_DONE  = 2'd2,
    S_DECAY = 2'd3
  } state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic                                prev_q, prev_d;
  logic                                rise_q, rise_d;
  logic                                frame_pend_q, frame_pend_d;
  logic                                decay_pend_q, decay_pend_d;
  logic                                overrun_q, overrun_d;
  logic [CNT_W-1:0]                    dcnt_q, dcnt_d;
  logic [NUM_BINS-1:0][15:0]           snap_q, snap_d;
  logic [NUM_BINS-1:0][3:0]            bar_q, bar_d;
  logic [NUM_BINS-1:0][3:0]            peak_q, peak_d;
  logic [NUM_BINS-1:0][HOLD_W-1:0]     hold_q, hold_d;

  // Single magnitude datapath on the currently indexed snapshot bin.
  logic [15:0]       bin_w;
  logic [8:0]        re_ext, im_ext, re_abs, im_abs, mag, mag_sh;
  logic [3:0]        lvl;
  logic [3:0]        cur_bar, cur_peak, new_bar;
  logic [HOLD_W-1:0] cur_hold;
  logic              decay_tick;

  assign bin_w  = snap_q[idx_q];
  // Sign-extend to 9 bits first so that |-128| = 128 does not wrap.
  assign re_ext = {bin_w[15], bin_w[15:8]};
  assign im_ext = {bin_w[7], bin_w[7:0]};
  assign re_abs = re_ext[8] ? (9'd0 - re_ext) : re_ext;
  assign im_abs = im_ext[8] ? (9'd0 - im_ext) : im_ext;
  assign mag    = re_abs + im_abs;
  assign mag_sh = mag >> LVL_SHIFT;
  assign lvl    = (mag_sh > 9'd15) ? 4'd15 : mag_sh[3:0];

  assign cur_bar  = bar_q[idx_q];
  assign cur_peak = peak_q[idx_q];
  assign cur_hold = hold_q[idx_q];
  assign new_bar  = (cur_bar != 4'd0) ? (cur_bar - 4'd1) : 4'd0;

  assign decay_tick = (dcnt_q == DCNT_MAX);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    prev_d       = i_frame_valid;
    rise_d       = i_frame_valid & ~prev_q;
    frame_pend_d = frame_pend_q;
    decay_pend_d = decay_pend_q;
    overrun_d    = overrun_q;
    dcnt_d       = decay_tick ? '0 : (dcnt_q + 1'b1);
    snap_d       = snap_q;
    bar_d        = bar_q;
    peak_d       = peak_q;
    hold_d       = hold_q;

    // Edges arriving outside IDLE are coalesced into one pending frame.
    if (rise_q && (state_q != S_IDLE)) begin
      if (frame_pend_q) begin
        overrun_d = 1'b1;
      end
      frame_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rise_q || frame_pend_q) begin
          state_d      = S_PROC;
          snap_d       = i_freqs;
          frame_pend_d = 1'b0;
          idx_d        = '0;
        end else if (decay_pend_q) begin
          state_d      = S_DECAY;
          decay_pend_d = 1'b0;
          idx_d        = '0;
        end
      end

      S_PROC: begin
        if (lvl > cur_bar) begin
          bar_d[idx_q] = lvl;
        end
        if (lvl >= cur_peak) begin
          peak_d[idx_q] = lvl;
          hold_d[idx_q] = HOLD_LOAD;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_DECAY: begin
        bar_d[idx_q] = new_bar;
        if (cur_hold != '0) begin
          hold_d[idx_q] = cur_hold - 1'b1;
        end else if (cur_peak > new_bar) begin
          peak_d[idx_q] = cur_peak - 4'd1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A tick landing on the same cycle as DECAY entry must survive.
    if (decay_tick) begin
      decay_pend_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      prev_q       <= 1'b0;
      rise_q       <= 1'b0;
      frame_pend_q <= 1'b0;
      decay_pend_q <= 1'b0;
      overrun_q    <= 1'b0;
      dcnt_q       <= '0;
      snap_q       <= '0;
      bar_q        <= '0;
      peak_q       <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      prev_q       <= prev_d;
      rise_q       <= rise_d;
      frame_pend_q <= frame_pend_d;
      decay_pend_q <= decay_pend_d;
      overrun_q    <= overrun_d;
      dcnt_q       <= dcnt_d;
      snap_q       <= snap_d;
      bar_q        <= bar_d;
      peak_q       <= peak_d;
      hold_q       <= hold_d;
    end
  end

  assign o_bar     = bar_q;
  assign o_peak    = peak_q;
  assign o_update  = (state_q == S_DONE);
  assign o_busy    = (state_q == S_PROC) || (state_q == S_DECAY);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_spectrum_bar_meter.sv
// Testbench for spectrum_bar_meter: directed scenarios plus randomized frames.
// A queue holds the frame data each launched sweep must consume; a monitor
// pops it on o_update and checks bars/peaks against an array model that
// applies the attack, decay and peak-hold rules bin by bin.
module tb_spectrum_bar_meter;

  localparam int NB        = 16;
  localparam int LVL_SHIFT = 4;
  localparam int DECAY     = 64;
  localparam int HOLD      = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           valid = 1'b0;
  logic [255:0]   freqs = '0;
  logic [63:0]    o_bar, o_peak;
  logic           o_update, o_busy, o_overrun;

  always #5 clk = ~clk;

  spectrum_bar_meter #(
    .NUM_BINS(NB), .LVL_SHIFT(LVL_SHIFT), .DECAY_CYCLES(DECAY), .HOLD_TICKS(HOLD)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(valid), .i_freqs(freqs),
    .o_bar(o_bar), .o_peak(o_peak), .o_update(o_update), .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  int decay_cnt = 0;
  logic [255:0] frame_q[$];
  int m_bar[NB];
  int m_peak[NB];
  int m_hold[NB];
  bit busy_prev = 1'b0;

  task automatic check_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT, got no event, expected one", name);
  endtask

  // Reference: level = min(15, (|re|+|im|) / 2^LVL_SHIFT)
  function automatic int level_of(input logic [15:0] b);
    int re, im, m;
    re = int'($signed(b[15:8]));
    im = int'($signed(b[7:0]));
    m  = (re < 0 ? -re : re) + (im < 0 ? -im : im);
    m  = m / (1 << LVL_SHIFT);
    return (m > 15) ? 15 : m;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      m_bar[k] = 0; m_peak[k] = 0; m_hold[k] = 0;
    end
  endtask

  task automatic model_frame(input logic [255:0] f);
    int l;
    for (int k = 0; k < NB; k++) begin
      l = level_of(f[k*16 +: 16]);
      if (l > m_bar[k]) m_bar[k] = l;
      if (l >= m_peak[k]) begin
        m_peak[k] = l;
        m_hold[k] = HOLD;
      end
    end
  endtask

  task automatic model_decay();
    for (int k = 0; k < NB; k++) begin
      if (m_bar[k] > 0) m_bar[k] = m_bar[k] - 1;
      if (m_hold[k] > 0) m_hold[k] = m_hold[k] - 1;
      else if (m_peak[k] > m_bar[k]) m_peak[k] = m_peak[k] - 1;
    end
  endtask

  function automatic logic [63:0] exp_bar();
    logic [63:0] v;
    for (int k = 0; k < NB; k++) v[k*4 +: 4] = 4'(m_bar[k]);
    return v;
  endfunction

  function automatic logic [63:0] exp_peak();
    logic [63:0] v;
    for (int k = 0; k < NB; k++) v[k*4 +: 4] = 4'(m_peak[k]);
    return v;
  endfunction

  // Monitor: sweep completions are the DUT's output events.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (o_update) begin
        if (frame_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_update: o_update=1 with no frame outstanding, expected 0");
        end else begin
          model_frame(frame_q.pop_front());
          check_vec("frame_bar", o_bar, exp_bar());
          check_vec("frame_peak", o_peak, exp_peak());
        end
        upd_cnt++;
      end else if (busy_prev && !o_busy) begin
        model_decay();
        check_vec("decay_bar", o_bar, exp_bar());
        check_vec("decay_peak", o_peak, exp_peak());
        decay_cnt++;
      end
      busy_prev = o_busy;
    end
  end

  // Called at posedge+1: valid is sampled high by exactly one clock edge.
  task automatic pulse();
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [255:0] f);
    freqs = f;
    frame_q.push_back(f);
    pulse();
  endtask

  task automatic wait_update(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_update !== 1'b1 && n < budget);
    if (o_update !== 1'b1) timeout_fail(name);
  endtask

  task automatic wait_decays(input string name, input int cnt, input int budget);
    int target, n;
    target = decay_cnt + cnt;
    n = 0;
    while (decay_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (decay_cnt < target) timeout_fail(name);
  endtask

  task automatic wait_busy(input string name, input logic lvl, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy !== lvl && n < budget);
    if (o_busy !== lvl) timeout_fail(name);
  endtask

  logic [255:0] f8, fsat, f10, f5, fr;

  initial begin
    int n, busy_n, u0;
    f8   = {16{16'h40C0}};
    f10  = {16{16'h50B0}};
    f5   = {16{16'h2828}};
    fsat = '0;
    fsat[15:0]  = 16'h8080;
    fsat[31:16] = 16'h7F00;
    model_reset();

    // Reset values
    #12;
    check_vec("rst_bar", o_bar, 64'h0);
    check_vec("rst_peak", o_peak, 64'h0);
    check_int("rst_update", int'(o_update), 0);
    check_int("rst_busy", int'(o_busy), 0);
    check_int("rst_overrun", int'(o_overrun), 0);
    @(negedge clk); rst_n = 1'b1;

    // Level-8 frame, latency counted in clock periods from the launch edge
    @(posedge clk); #1;
    freqs = f8;
    frame_q.push_back(f8);
    valid = 1'b1;
    n = 0; busy_n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) valid = 1'b0;
      if (o_busy) busy_n++;
      if (o_update) break;
    end
    check_int("update_latency", n, 19);
    check_int("busy_cycles", busy_n, 16);
    check_vec("lvl8_bar", o_bar, 64'h8888_8888_8888_8888);
    check_vec("lvl8_peak", o_peak, 64'h8888_8888_8888_8888);

    // Ten decay ticks bring everything to zero
    wait_decays("decay10", 10, 12 * DECAY);
    check_vec("decay10_bar", o_bar, 64'h0);
    check_vec("decay10_peak", o_peak, 64'h0);

    // Saturation
    @(posedge clk); #1;
    launch(fsat);
    wait_update("sat", 60);
    check_vec("sat_bar", o_bar, 64'h0000_0000_0000_007F);
    check_vec("sat_peak", o_peak, 64'h0000_0000_0000_007F);
    wait_decays("sat_decay", 18, 20 * DECAY);

    // Attack over decay
    @(posedge clk); #1;
    launch(f8);
    wait_update("attack_pre", 60);
    wait_decays("attack_decay5", 5, 7 * DECAY);
    check_vec("bar_at3", o_bar, 64'h3333_3333_3333_3333);
    check_vec("peak_at5", o_peak, 64'h5555_5555_5555_5555);
    @(posedge clk); #1;
    launch(f10);
    wait_update("attack10", 40);
    check_vec("attack10_bar", o_bar, 64'hAAAA_AAAA_AAAA_AAAA);
    @(posedge clk); #1;
    launch(f5);
    wait_update("attack5", 40);
    check_vec("lower_bar", o_bar, 64'hAAAA_AAAA_AAAA_AAAA);
    check_vec("lower_peak", o_peak, 64'hAAAA_AAAA_AAAA_AAAA);

    // Frame edge during a DECAY sweep is served right after it
    wait_busy("col1_idle", 1'b0, 100);
    wait_busy("col1_decay", 1'b1, 2 * DECAY);
    @(posedge clk); #1;
    launch(f8);
    check_int("overrun_single", int'(o_overrun), 0);
    wait_update("collide1", 40);
    // Two edges during DECAY: coalesced into one sweep, overrun set
    wait_busy("col2_idle", 1'b0, 100);
    wait_busy("col2_decay", 1'b1, 2 * DECAY);
    @(posedge clk); #1;
    launch(fsat);
    pulse();
    check_int("overrun_double", int'(o_overrun), 1);
    wait_update("collide2", 40);
    @(negedge clk);
    check_int("queue_drained", frame_q.size(), 0);

    // Randomized frames
    for (int r = 0; r < 30; r++) begin
      @(posedge clk); #1;
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
      for (int k = 0; k < NB; k++) begin
        if ($urandom_range(0, 3) == 0)
          fr[k*16 +: 16] = {8'($urandom_range(0, 31)), 8'($urandom_range(0, 31))};
        else
          fr[k*16 +: 16] = 16'($urandom_range(0, 65535));
      end
      launch(fr);
      wait_update("rand_frame", 120);
    end
    check_int("overrun_sticky", int'(o_overrun), 1);

    // Reset in the middle of a PROC sweep (idx 7)
    wait_decays("pre_reset", 1, 2 * DECAY);
    @(posedge clk); #1;
    launch(f10);
    repeat (7) @(posedge clk);
    #1;
    check_int("busy_at_idx7", int'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    frame_q.delete();
    model_reset();
    check_vec("mid_rst_bar", o_bar, 64'h0);
    check_vec("mid_rst_peak", o_peak, 64'h0);
    check_int("mid_rst_update", int'(o_update), 0);
    check_int("mid_rst_busy", int'(o_busy), 0);
    check_int("mid_rst_overrun", int'(o_overrun), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    u0 = upd_cnt;
    repeat (200) @(negedge clk);
    check_int("no_update_after_reset", upd_cnt, u0);
    check_int("overrun_after_reset", int'(o_overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
